// File: rtl/seq_pkg.sv
// Shared definitions for the HI/LO move sequencer: state codes, default opcodes
// and the bit positions of the internal one-hot strobe vector.
package seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_HALT = 4'd7,
    ST_ERR  = 4'd8
  } state_t;

  localparam logic [4:0] OPC_MFHI = 5'b11000;
  localparam logic [4:0] OPC_MFLO = 5'b11001;
  localparam logic [4:0] OPC_MTHI = 5'b10110;
  localparam logic [4:0] OPC_MTLO = 5'b10111;

  localparam int STB_PCOUT   = 0;
  localparam int STB_MARIN   = 1;
  localparam int STB_INCPC   = 2;
  localparam int STB_ZLOWIN  = 3;
  localparam int STB_ZLOWOUT = 4;
  localparam int STB_PCIN    = 5;
  localparam int STB_READ    = 6;
  localparam int STB_MDREAD  = 7;
  localparam int STB_MDRIN   = 8;
  localparam int STB_MDROUT  = 9;
  localparam int STB_IRIN    = 10;
  localparam int STB_GRA     = 11;
  localparam int STB_RIN     = 12;
  localparam int STB_ROUT    = 13;
  localparam int STB_HIIN    = 14;
  localparam int STB_HIOUT   = 15;
  localparam int STB_LOIN    = 16;
  localparam int STB_LOOUT   = 17;
  localparam int STB_W       = 18;

endpackage

// File: rtl/move_decode.sv
// Combinational opcode decoder for the HI/LO move group.
// to_reg=1 means HI/LO is copied into the general register (mfhi/mflo).
module move_decode
  import seq_pkg::*;
#(
  parameter int               OPC_W   = 5,
  parameter logic [OPC_W-1:0] OP_MFHI = OPC_MFHI,
  parameter logic [OPC_W-1:0] OP_MFLO = OPC_MFLO,
  parameter logic [OPC_W-1:0] OP_MTHI = OPC_MTHI,
  parameter logic [OPC_W-1:0] OP_MTLO = OPC_MTLO
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             hi_sel,
  output logic             lo_sel,
  output logic             to_reg,
  output logic             legal
);

  // opcode to move-direction decode
  always_comb begin
    hi_sel = 1'b0;
    lo_sel = 1'b0;
    to_reg = 1'b0;
    legal  = 1'b0;
    case (opcode)
      OP_MFHI: begin hi_sel = 1'b1; to_reg = 1'b1; legal = 1'b1; end
      OP_MFLO: begin lo_sel = 1'b1; to_reg = 1'b1; legal = 1'b1; end
      OP_MTHI: begin hi_sel = 1'b1; legal = 1'b1; end
      OP_MTLO: begin lo_sel = 1'b1; legal = 1'b1; end
      default: begin
        hi_sel = 1'b0;
        lo_sel = 1'b0;
        to_reg = 1'b0;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/move_sequencer.sv
// Hardwired T-state sequencer for instruction fetch and mfhi/mflo/mthi/mtlo.
// Strobes are Moore outputs of the state register; only T4 also looks at ir.
module move_sequencer
  import seq_pkg::*;
#(
  parameter int                         IR_W     = 32,
  parameter int                         OPC_MSB  = 31,
  parameter int                         OPC_LSB  = 27,
  parameter logic [OPC_MSB-OPC_LSB:0]   OP_MFHI  = OPC_MFHI,
  parameter logic [OPC_MSB-OPC_LSB:0]   OP_MFLO  = OPC_MFLO,
  parameter logic [OPC_MSB-OPC_LSB:0]   OP_MTHI  = OPC_MTHI,
  parameter logic [OPC_MSB-OPC_LSB:0]   OP_MTLO  = OPC_MTLO,
  parameter int                         WAIT_MAX = 15,
  parameter int                         COUNT_W  = 16
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               run,
  input  logic [IR_W-1:0]    ir,
  input  logic               mem_ready,
  output logic               PCout,
  output logic               MARin,
  output logic               IncPC,
  output logic               Zlowin,
  output logic               Zlowout,
  output logic               PCin,
  output logic               Read,
  output logic               MD_read,
  output logic               MDRin,
  output logic               MDRout,
  output logic               IRin,
  output logic               Gra,
  output logic               Rin,
  output logic               Rout,
  output logic               HIin,
  output logic               HIout,
  output logic               LOin,
  output logic               LOout,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               mem_err,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] retired
);

  localparam int OPC_W  = OPC_MSB - OPC_LSB + 1;
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_t             cur_state;
  state_t             next_state;
  logic [STB_W-1:0]   stb;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               t1_entry;
  logic               wait_hit;
  logic               hi_sel;
  logic               lo_sel;
  logic               to_reg;
  logic               legal;
  logic               unused_ir;

  assign unused_ir = ^ir[OPC_LSB-1:0];

  move_decode #(
    .OPC_W   (OPC_W),
    .OP_MFHI (OP_MFHI),
    .OP_MFLO (OP_MFLO),
    .OP_MTHI (OP_MTHI),
    .OP_MTLO (OP_MTLO)
  ) u_decode (
    .opcode (ir[OPC_MSB:OPC_LSB]),
    .hi_sel (hi_sel),
    .lo_sel (lo_sel),
    .to_reg (to_reg),
    .legal  (legal)
  );

  // The wait counter is zero only on the first T1 cycle, so it doubles as the entry flag.
  assign t1_entry = (wait_cnt == '0);
  assign wait_hit = (wait_cnt == WAIT_W'(WAIT_MAX - 1));

  // state register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // next-state and strobe decode
  always_comb begin
    next_state = cur_state;
    stb        = '0;
    done       = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (run) next_state = ST_T0;
        else     next_state = ST_IDLE;
      end
      ST_T0: begin
        stb[STB_PCOUT]  = 1'b1;
        stb[STB_MARIN]  = 1'b1;
        stb[STB_INCPC]  = 1'b1;
        stb[STB_ZLOWIN] = 1'b1;
        next_state      = ST_T1;
      end
      ST_T1: begin
        stb[STB_READ]    = 1'b1;
        stb[STB_ZLOWOUT] = t1_entry;
        stb[STB_PCIN]    = t1_entry;
        if (mem_ready)     next_state = ST_T2;
        else if (wait_hit) next_state = ST_ERR;
        else               next_state = ST_T1;
      end
      ST_T2: begin
        stb[STB_MDREAD] = 1'b1;
        stb[STB_MDRIN]  = 1'b1;
        next_state      = ST_T3;
      end
      ST_T3: begin
        stb[STB_MDROUT] = 1'b1;
        stb[STB_IRIN]   = 1'b1;
        next_state      = ST_T4;
      end
      ST_T4: begin
        if (legal) begin
          // Exactly one bus driver and one destination latch per move.
          stb[STB_GRA]   = 1'b1;
          stb[STB_RIN]   = to_reg;
          stb[STB_ROUT]  = ~to_reg;
          stb[STB_HIOUT] = to_reg & hi_sel;
          stb[STB_LOOUT] = to_reg & lo_sel;
          stb[STB_HIIN]  = ~to_reg & hi_sel;
          stb[STB_LOIN]  = ~to_reg & lo_sel;
          next_state     = ST_T5;
        end else begin
          next_state = ST_HALT;
        end
      end
      ST_T5: begin
        done = 1'b1;
        if (run) next_state = ST_T0;
        else     next_state = ST_IDLE;
      end
      ST_HALT: next_state = ST_HALT;
      ST_ERR:  next_state = ST_ERR;
      default: next_state = ST_IDLE;
    endcase
  end

  // wait counter, sticky fault flags and retired count
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wait_cnt <= '0;
      illegal  <= 1'b0;
      mem_err  <= 1'b0;
      retired  <= '0;
    end else begin
      if (cur_state == ST_T1 && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                  wait_cnt <= '0;
      if (cur_state == ST_T4 && !legal) illegal <= 1'b1;
      if (cur_state == ST_T1 && !mem_ready && wait_hit) mem_err <= 1'b1;
      if (cur_state == ST_T5) retired <= retired + COUNT_W'(1);
    end
  end

  assign busy = (cur_state != ST_IDLE) && (cur_state != ST_HALT) && (cur_state != ST_ERR);
  assign state = cur_state;

  assign PCout   = stb[STB_PCOUT];
  assign MARin   = stb[STB_MARIN];
  assign IncPC   = stb[STB_INCPC];
  assign Zlowin  = stb[STB_ZLOWIN];
  assign Zlowout = stb[STB_ZLOWOUT];
  assign PCin    = stb[STB_PCIN];
  assign Read    = stb[STB_READ];
  assign MD_read = stb[STB_MDREAD];
  assign MDRin   = stb[STB_MDRIN];
  assign MDRout  = stb[STB_MDROUT];
  assign IRin    = stb[STB_IRIN];
  assign Gra     = stb[STB_GRA];
  assign Rin     = stb[STB_RIN];
  assign Rout    = stb[STB_ROUT];
  assign HIin    = stb[STB_HIIN];
  assign HIout   = stb[STB_HIOUT];
  assign LOin    = stb[STB_LOIN];
  assign LOout   = stb[STB_LOOUT];

endmodule

// File: tb/tb_move_sequencer.sv
// Cycle-table bench: each stimulus cycle queues the outputs expected in that
// cycle; a negedge monitor pops and compares them against the DUT.
module tb_move_sequencer;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MD_read, MDRin, MDRout, IRin;
  logic Gra, Rin, Rout, HIin, HIout, LOin, LOout;
  logic busy, done, illegal, mem_err;
  logic [3:0] state;
  logic [1:0] retired;

  move_sequencer #(.COUNT_W(2)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin), .Zlowout(Zlowout),
    .PCin(PCin), .Read(Read), .MD_read(MD_read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Gra(Gra), .Rin(Rin), .Rout(Rout), .HIin(HIin), .HIout(HIout),
    .LOin(LOin), .LOout(LOout), .busy(busy), .done(done), .illegal(illegal),
    .mem_err(mem_err), .state(state), .retired(retired)
  );

  always #5 clock = ~clock;

  localparam logic [17:0] B_PCOUT   = 18'h1 << 17;
  localparam logic [17:0] B_MARIN   = 18'h1 << 16;
  localparam logic [17:0] B_INCPC   = 18'h1 << 15;
  localparam logic [17:0] B_ZLOWIN  = 18'h1 << 14;
  localparam logic [17:0] B_ZLOWOUT = 18'h1 << 13;
  localparam logic [17:0] B_PCIN    = 18'h1 << 12;
  localparam logic [17:0] B_READ    = 18'h1 << 11;
  localparam logic [17:0] B_MDREAD  = 18'h1 << 10;
  localparam logic [17:0] B_MDRIN   = 18'h1 << 9;
  localparam logic [17:0] B_MDROUT  = 18'h1 << 8;
  localparam logic [17:0] B_IRIN    = 18'h1 << 7;
  localparam logic [17:0] B_GRA     = 18'h1 << 6;
  localparam logic [17:0] B_RIN     = 18'h1 << 5;
  localparam logic [17:0] B_ROUT    = 18'h1 << 4;
  localparam logic [17:0] B_HIIN    = 18'h1 << 3;
  localparam logic [17:0] B_HIOUT   = 18'h1 << 2;
  localparam logic [17:0] B_LOIN    = 18'h1 << 1;
  localparam logic [17:0] B_LOOUT   = 18'h1;

  localparam logic [17:0] X_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
  localparam logic [17:0] X_T1F  = B_ZLOWOUT | B_PCIN | B_READ;
  localparam logic [17:0] X_RD   = B_READ;
  localparam logic [17:0] X_T2   = B_MDREAD | B_MDRIN;
  localparam logic [17:0] X_T3   = B_MDROUT | B_IRIN;
  localparam logic [17:0] X_MFHI = B_HIOUT | B_GRA | B_RIN;
  localparam logic [17:0] X_MFLO = B_LOOUT | B_GRA | B_RIN;
  localparam logic [17:0] X_MTHI = B_GRA | B_ROUT | B_HIIN;
  localparam logic [17:0] X_MTLO = B_GRA | B_ROUT | B_LOIN;
  localparam logic [17:0] X_NONE = 18'h0;

  localparam logic [31:0] IR_MFHI = 32'hC080_0000;
  localparam logic [31:0] IR_MFLO = 32'hC880_0000;
  localparam logic [31:0] IR_MTHI = 32'hB080_0000;
  localparam logic [31:0] IR_MTLO = 32'hB880_0000;
  localparam logic [31:0] IR_BAD  = 32'h0000_1234;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] stb;
    logic        done;
    logic        busy;
    logic        ill;
    logic        me;
    logic [1:0]  ret;
    string       name;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       exp_ill = 1'b0;
  logic       exp_me  = 1'b0;
  logic [1:0] exp_ret = 2'd0;

  wire [17:0] act_stb = {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MD_read,
                         MDRin, MDRout, IRin, Gra, Rin, Rout, HIin, HIout, LOin, LOout};

  // monitor: compare every queued expectation mid-cycle
  exp_t e_mon;
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      n_vec++;
      if ({state, act_stb, done, busy, illegal, mem_err, retired} !==
          {e_mon.st, e_mon.stb, e_mon.done, e_mon.busy, e_mon.ill, e_mon.me, e_mon.ret}) begin
        n_err++;
        $display("FAIL %s @%0t: got st=%0d stb=%05h done=%b busy=%b ill=%b me=%b ret=%0d, want st=%0d stb=%05h done=%b busy=%b ill=%b me=%b ret=%0d",
                 e_mon.name, $time, state, act_stb, done, busy, illegal, mem_err, retired,
                 e_mon.st, e_mon.stb, e_mon.done, e_mon.busy, e_mon.ill, e_mon.me, e_mon.ret);
      end
    end
  end

  task automatic cyc(input logic clr, input logic r, input logic mr, input logic [31:0] irv,
                     input logic [3:0] st, input logic [17:0] stb, input logic dn,
                     input string nm);
    exp_t e;
    clear = clr; run = r; mem_ready = mr; ir = irv;
    if (!clr) begin exp_ill = 1'b0; exp_me = 1'b0; exp_ret = 2'd0; end
    e.st = st; e.stb = stb; e.done = dn;
    e.busy = (st >= 4'd1) && (st <= 4'd6);
    e.ill = exp_ill; e.me = exp_me; e.ret = exp_ret; e.name = nm;
    sb.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic instr(input logic [31:0] irv, input logic [17:0] t4, input int stalls,
                       input logic run_mid, input logic run_end, input string nm);
    cyc(1'b1, run_mid, 1'b0, irv, 4'd1, X_T0, 1'b0, {nm, "_t0"});
    cyc(1'b1, run_mid, (stalls == 0), irv, 4'd2, X_T1F, 1'b0, {nm, "_t1"});
    for (int i = 1; i <= stalls; i++)
      cyc(1'b1, run_mid, (i == stalls), irv, 4'd2, X_RD, 1'b0, {nm, "_t1w"});
    cyc(1'b1, run_mid, 1'b0, irv, 4'd3, X_T2, 1'b0, {nm, "_t2"});
    cyc(1'b1, run_mid, 1'b0, irv, 4'd4, X_T3, 1'b0, {nm, "_t3"});
    cyc(1'b1, run_mid, 1'b0, irv, 4'd5, t4, 1'b0, {nm, "_t4"});
    cyc(1'b1, run_end, 1'b0, irv, 4'd6, X_NONE, 1'b1, {nm, "_t5"});
    exp_ret = exp_ret + 2'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = 32'h0;
    @(posedge clock); #1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'd0, X_NONE, 1'b0, "reset");
    cyc(1'b0, 1'b1, 1'b1, 32'h0, 4'd0, X_NONE, 1'b0, "reset_run");
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'd0, X_NONE, 1'b0, "idle");
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 4'd0, X_NONE, 1'b0, "idle_go");
    // fetch + mfhi, then mflo and mthi back to back
    instr(IR_MFHI, X_MFHI, 0, 1'b1, 1'b1, "mfhi");
    instr(IR_MFLO, X_MFLO, 0, 1'b1, 1'b1, "mflo");
    instr(IR_MTHI, X_MTHI, 0, 1'b1, 1'b0, "mthi");
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'd0, X_NONE, 1'b0, "idle_after");
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 4'd0, X_NONE, 1'b0, "idle_go2");
    // 3 stall cycles with run dropped mid-instruction; retired wraps 3 -> 0
    instr(IR_MTLO, X_MTLO, 3, 1'b0, 1'b1, "stall3");
    // mem_ready arrives on the last T1 cycle before timeout
    instr(IR_MTLO, X_MTLO, 14, 1'b1, 1'b0, "stall14");
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 4'd0, X_NONE, 1'b0, "idle_go3");
    // async reset during T2
    cyc(1'b1, 1'b1, 1'b0, IR_MFHI, 4'd1, X_T0, 1'b0, "rst_t0");
    cyc(1'b1, 1'b1, 1'b1, IR_MFHI, 4'd2, X_T1F, 1'b0, "rst_t1");
    cyc(1'b0, 1'b1, 1'b0, IR_MFHI, 4'd0, X_NONE, 1'b0, "rst_async");
    cyc(1'b0, 1'b1, 1'b0, IR_MFHI, 4'd0, X_NONE, 1'b0, "rst_hold");
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 4'd0, X_NONE, 1'b0, "rst_restart");
    // five mtlo back to back: retired 1,2,3,0,1
    instr(IR_MTLO, X_MTLO, 0, 1'b1, 1'b1, "wrap1");
    instr(IR_MTLO, X_MTLO, 0, 1'b1, 1'b1, "wrap2");
    instr(IR_MTLO, X_MTLO, 0, 1'b1, 1'b1, "wrap3");
    instr(IR_MTLO, X_MTLO, 0, 1'b1, 1'b1, "wrap4");
    instr(IR_MTLO, X_MTLO, 0, 1'b1, 1'b0, "wrap5");
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 4'd0, X_NONE, 1'b0, "idle_go4");
    // illegal opcode reaches HALT and stays there
    cyc(1'b1, 1'b1, 1'b0, IR_BAD, 4'd1, X_T0, 1'b0, "ill_t0");
    cyc(1'b1, 1'b1, 1'b1, IR_BAD, 4'd2, X_T1F, 1'b0, "ill_t1");
    cyc(1'b1, 1'b1, 1'b0, IR_BAD, 4'd3, X_T2, 1'b0, "ill_t2");
    cyc(1'b1, 1'b1, 1'b0, IR_BAD, 4'd4, X_T3, 1'b0, "ill_t3");
    cyc(1'b1, 1'b1, 1'b0, IR_BAD, 4'd5, X_NONE, 1'b0, "ill_t4");
    exp_ill = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, IR_BAD, 4'd7, X_NONE, 1'b0, "halt_a");
    cyc(1'b1, 1'b1, 1'b1, IR_MFHI, 4'd7, X_NONE, 1'b0, "halt_b");
    cyc(1'b1, 1'b0, 1'b0, IR_MFHI, 4'd7, X_NONE, 1'b0, "halt_c");
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'd0, X_NONE, 1'b0, "halt_clear");
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 4'd0, X_NONE, 1'b0, "idle_go5");
    // memory never ready: 15 T1 cycles then ERR
    cyc(1'b1, 1'b1, 1'b0, IR_MFHI, 4'd1, X_T0, 1'b0, "to_t0");
    cyc(1'b1, 1'b1, 1'b0, IR_MFHI, 4'd2, X_T1F, 1'b0, "to_t1");
    for (int i = 0; i < 14; i++)
      cyc(1'b1, 1'b1, 1'b0, IR_MFHI, 4'd2, X_RD, 1'b0, "to_t1w");
    exp_me = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, IR_MFHI, 4'd8, X_NONE, 1'b0, "err_a");
    cyc(1'b1, 1'b0, 1'b1, IR_MFHI, 4'd8, X_NONE, 1'b0, "err_b");
    cyc(1'b1, 1'b1, 1'b0, IR_MFHI, 4'd8, X_NONE, 1'b0, "err_c");
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'd0, X_NONE, 1'b0, "err_clear");
    @(negedge clock); #1;
    if (state !== 4'd0) begin
      n_err++;
      $display("FAIL final_state: got %0d want 0", state);
    end
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL final_busy: got %b want 0", busy);
    end
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL final_done: got %b want 0", done);
    end
    if (illegal !== 1'b0) begin
      n_err++;
      $display("FAIL final_illegal: got %b want 0", illegal);
    end
    if (mem_err !== 1'b0) begin
      n_err++;
      $display("FAIL final_mem_err: got %b want 0", mem_err);
    end
    if (retired !== 2'd0) begin
      n_err++;
      $display("FAIL final_retired: got %0d want 0", retired);
    end
    if (act_stb !== 18'h0) begin
      n_err++;
      $display("FAIL final_strobes: got %05h want 0", act_stb);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else            $display("FAIL %0d errors", n_err);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Hardwired control sequencer that replaces hand-driven T-state strobes for instruction fetch and the HI/LO move group: mfhi, mflo, mthi, mtlo.
- Drives the existing datapath control inputs directly.
- Reads back the IR contents to decode the instruction.
- Stalls on memory-ready and reports illegal-opcode and memory-timeout faults.

Parameters:
- IR_W, 32, instruction register width
- OPC_MSB, 31, opcode field MSB in ir
- OPC_LSB, 27, opcode field LSB in ir
- OP_MFHI, 5'b11000, mfhi opcode
- OP_MFLO, 5'b11001, mflo opcode
- OP_MTHI, 5'b10110, mthi opcode
- OP_MTLO, 5'b10111, mtlo opcode
- WAIT_MAX, 15, T1 cycles without mem_ready before fault
- COUNT_W, 16, retired-instruction counter width

Ports:
- clock  in  1  system clock; all state changes on rising edge
- clear  in  1  asynchronous active-low reset
- run  in  1  level; start/continue sequencing
- ir  in  IR_W  datapath IR contents
- mem_ready  in  1  memory read data valid
- PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MD_read, MDRin, MDRout, IRin  out  1 each  fetch strobes
- Gra, Rin, Rout, HIin, HIout, LOin, LOout  out  1 each  execute strobes
- busy  out  1  state not IDLE/HALT/ERR
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  sticky illegal-opcode flag
- mem_err  out  1  sticky memory-timeout flag
- state  out  4  current state code
- retired  out  COUNT_W  retired-instruction count

Behaviour:
- Reset:
  - clear=0 forces IDLE immediately, asynchronously.
  - All strobes, done, illegal, mem_err and retired go to 0, and the wait counter clears.
- Outputs: Moore, decoded from the registered state (plus ir in T4 only). Each strobe is asserted for whole cycles; no glitches between adjacent states.
- State codes: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, HALT=7, ERR=8.
- State actions and transitions:
  - IDLE: no strobes. Go to T0 when run=1.
  - T0: PCout, MARin, IncPC, Zlowin. Go to T1.
  - T1: Zlowout, PCin on entry cycle only; Read held every cycle in T1.
    - mem_ready=1 → T2.
    - Otherwise the wait counter increments. When it reaches WAIT_MAX → ERR and mem_err=1.
  - T2: MD_read, MDRin. Go to T3.
  - T3: MDRout, IRin. Go to T4. IR is valid from T4 onward.
  - T4: decode ir[OPC_MSB:OPC_LSB]:
    - mfhi → HIout, Gra, Rin.
    - mflo → LOout, Gra, Rin.
    - mthi → Gra, Rout, HIin.
    - mtlo → Gra, Rout, LOin.
    - Any other opcode → no strobes, illegal=1, go to HALT.
    - Legal opcode → T5.
  - T5: no strobes; done=1; retired increments.
    - run=1 → T0 (back-to-back issue).
    - run=0 → IDLE.
- Latency: 6 cycles T0..T5 per instruction with mem_ready=1 in the first T1 cycle. Each stall cycle adds 1.
- run deassertion mid-instruction is ignored; the current instruction completes, then the block goes to IDLE.
- HALT and ERR are terminal. Only clear exits them; run is ignored there.
- Wait counter: resets on entering T1. It counts only T1 cycles with mem_ready=0. mem_ready=1 arriving in the same cycle the counter would reach WAIT_MAX wins (→ T2).
- retired wraps modulo 2^COUNT_W with no flag.
- At most one of {HIin, LOin, Rin} and at most one bus driver are asserted in any cycle. Bus drivers are PCout, Zlowout, MDRout, HIout, LOout and Rout.

Decomposition:
- Shared package `seq_pkg`:
  - state code localparams.
  - default opcode constants.
  - one-hot strobe-vector bit indices.
- One sub-module `move_decode`: combinational opcode → {hi_sel, lo_sel, to_reg, legal}.
- The FSM, wait counter and retired counter stay in move_sequencer.

Test Plan:
- Fetch + mfhi: clear pulse, run=1, mem_ready=1, ir=32'hC0800000 → states 1,2,3,4,5,6 on successive edges; T4 has HIout=Gra=Rin=1; done pulse; retired=1.
- Back-to-back: run held, mflo then mthi (ir=32'hC8800000, 32'hB0800000) → retired=2 after 12 cycles; second T4 asserts Gra, Rout, HIin only.
- Stall and timeout:
  - mem_ready low 3 cycles → T1 lasts 4 cycles; Read held the whole time; PCin only on the first.
  - mem_ready never high → ERR after 15 T1 cycles; mem_err=1; busy=0.
- Illegal: ir opcode 5'b00000 at T4 → no strobes, illegal=1, state=7, done stays 0; run toggling leaves state=7.
- Reset mid-op: drop clear during T2 → all outputs 0 asynchronously, state=0, retired=0; restart proceeds from T0.
- Counter wrap: COUNT_W=2, run 5 mtlo instructions → retired sequence 1,2,3,0,1.
